// File: rtl/gate_arb_pkg.sv
// Shared definitions for gate_arbiter: controller state encoding and parameter limits.
package gate_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/wide_and.sv
// Shared gate bank: one 1-bit And cell per operand bit.

// Single 1-bit AND cell of the gate library.
module And (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module wide_and #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // One gate per bit; no arithmetic beyond the per-bit AND.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        And u_and (
            .a (a[i]),
            .b (b[i]),
            .y (y[i])
        );
    end

endmodule

// File: rtl/gate_arbiter.sv
// Shares one wide_and bank between NREQ valid/ready requesters.
// Define GATE_ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority (lowest index wins) and no pointer register is built.
import gate_arb_pkg::*;

module gate_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_out,
    output logic [IDW-1:0]        rsp_id
);

    // Reject out-of-range configurations at elaboration.
    if (NREQ < 2 || NREQ > MAX_NREQ || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_param_check
        $error("gate_arbiter: NREQ or WIDTH out of range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] and_y;
    logic [IDW-1:0]   gnt;
    logic             gnt_vld;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

`ifdef GATE_ARB_RR_EN
    logic [IDW-1:0]   ptr;

    // Round-robin search starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!gnt_vld && req_valid[IDW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt     = IDW'(idx);
            end
        end
    end
`else
    // Fixed priority: lowest asserted index wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_vld && req_valid[IDW'(k)]) begin
                gnt_vld = 1'b1;
                gnt     = IDW'(k);
            end
        end
    end
`endif

    // Acceptance is offered only in IDLE; operands of the granted slot are muxed out.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld) begin
            req_ready = NREQ'(1) << gnt;
        end
        sel_a = req_a[32'(gnt)*WIDTH +: WIDTH];
        sel_b = req_b[32'(gnt)*WIDTH +: WIDTH];
    end

    wide_and #(
        .WIDTH (WIDTH)
    ) u_wide_and (
        .a (a_q),
        .b (b_q),
        .y (and_y)
    );

    // Controller: latch on accept, capture gate result after one settle cycle, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_id    <= '0;
`ifdef GATE_ARB_RR_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= gnt;
                        state <= EVAL;
`ifdef GATE_ARB_RR_EN
                        ptr   <= (32'(gnt) == NREQ - 1) ? '0 : IDW'(32'(gnt) + 1);
`endif
                    end
                end
                EVAL: begin
                    rsp_out   <= and_y;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_arbiter.sv
// Directed bench for gate_arbiter (NREQ=4, WIDTH=8) plus a WIDTH=1 instance.
module tb_gate_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_out;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid1;
    logic [3:0]  req_ready1;
    logic [3:0]  req_a1;
    logic [3:0]  req_b1;
    logic        rsp_valid1;
    logic        rsp_ready1;
    logic [0:0]  rsp_out1;
    logic [1:0]  rsp_id1;

    int n_checks = 0;
    int n_pass   = 0;

    gate_arbiter #(.NREQ(4), .WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id)
    );

    gate_arbiter #(.NREQ(4), .WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_a     (req_a1),
        .req_b     (req_b1),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
        .rsp_out   (rsp_out1),
        .rsp_id    (rsp_id1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    // One transaction with rsp_ready held high: grant now, EVAL, HOLD, back to IDLE.
    task automatic serve(input int exp_id, input logic [7:0] exp_out);
        check("grant", 32'(req_ready), 32'(1) << exp_id);
        tick();
        check("eval_ready", 32'(req_ready), 32'h0);
        check("eval_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'h1);
        check("rsp_id", 32'(rsp_id), 32'(exp_id));
        check("rsp_out", 32'(rsp_out), 32'(exp_out));
        tick();
    endtask

    initial begin
        logic [3:0] exp1;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        req_valid1 = '0;
        req_a1     = '0;
        req_b1     = '0;
        rsp_ready1 = 1'b1;
        exp1       = 4'b1000;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_out", 32'(rsp_out), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);
        rst = 1'b0;
        #1;

        // Operand table: slot0 FF&0F=0F, slot1 AA&F0=A0, slot2 F0&3C=30, slot3 81&FF=81
        req_a = {8'h81, 8'hF0, 8'hAA, 8'hFF};
        req_b = {8'hFF, 8'h3C, 8'hF0, 8'h0F};

        // Single request from 2, then backpressure in HOLD
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        #1;
        check("eval_no_ready", 32'(req_ready), 32'h0);
        check("eval_no_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_out", 32'(rsp_out), 32'h30);
        check("single_id", 32'(rsp_id), 32'h2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_out", 32'(rsp_out), 32'h30);
            check("bp_id", 32'(rsp_id), 32'h2);
            check("bp_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", 32'(rsp_valid), 32'h0);
        serve(0, 8'h0F);
        req_valid = '0;

        // Dropped request is never accepted
        req_valid = 4'b0100;
        #1;
        check("drop_grant", 32'(req_ready), 32'h4);
        #2;
        req_valid = '0;
        tick();
        check("drop_ready", 32'(req_ready), 32'h0);
        check("drop_valid0", 32'(rsp_valid), 32'h0);
        tick();
        check("drop_valid1", 32'(rsp_valid), 32'h0);

        // Reset during EVAL, then 0 beats 3
        req_valid = 4'b1000;
        #1;
        check("mid_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_out", 32'(rsp_out), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_idle_valid", 32'(rsp_valid), 32'h0);
        req_valid = 4'b1001;
        #1;
        serve(0, 8'h0F);
        req_valid = '0;

        // Contention from a clean pointer
        pulse_reset();
`ifdef GATE_ARB_RR_EN
        req_valid = 4'b1111;
        #1;
        serve(0, 8'h0F);
        serve(1, 8'hA0);
        serve(2, 8'h30);
        serve(3, 8'h81);
        serve(0, 8'h0F);
`else
        req_valid = 4'b1010;
        #1;
        serve(1, 8'hA0);
        serve(1, 8'hA0);
        serve(1, 8'hA0);
        req_valid = 4'b1000;
        #1;
        serve(3, 8'h81);
`endif
        req_valid = '0;

        // WIDTH=1 exhaustive truth table on requester 0
        req_valid1 = 4'b0001;
        for (int p = 0; p < 4; p++) begin
            req_a1 = {3'b000, p[1]};
            req_b1 = {3'b000, p[0]};
            #1;
            check("w1_grant", 32'(req_ready1), 32'h1);
            tick();
            tick();
            check("w1_valid", 32'(rsp_valid1), 32'h1);
            check("w1_out", 32'(rsp_out1), 32'(exp1[p]));
            tick();
        end
        req_valid1 = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_arbiter.md
# gate_arbiter

Shares a single WIDTH-bit AND datapath (a bank of 1-bit `And` gates) between NREQ requesters. Each requester submits an operand pair over a valid/ready handshake. A three-state controller grants one requester at a time, evaluates the pair, and returns the registered result tagged with the requester index. It sits between client logic and the gate library and is the only owner of the shared gate bank.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand and result width in bits, 1..32.
- `IDW`, derived as $clog2(NREQ): width of the requester tag.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request strobe.
- `req_ready`  out  NREQ  one-hot acceptance; at most one bit set.
- `req_a`  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_out`  out  WIDTH  registered bitwise A & B.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_out`.

## Operation
- States:
  - IDLE: no transaction in flight.
  - EVAL: operands latched, gate bank settling.
  - HOLD: result presented on the response port.
- IDLE:
  - The arbiter picks grant g among the asserted `req_valid` bits.
  - `req_ready[g]` = 1. All other `req_ready` bits = 0, and all bits = 0 when no request is pending.
  - On `req_valid[g] & req_ready[g]`: latch `req_a[g]`, `req_b[g]` and g; advance to EVAL.
- EVAL: lasts exactly one cycle. On its edge `rsp_out` <= A & B and `rsp_id` <= g; advance to HOLD.
- HOLD:
  - `rsp_valid` = 1. `rsp_out` and `rsp_id` stay stable until the handshake.
  - On `rsp_ready`: return to IDLE.
- `req_ready` is 0 in EVAL and HOLD. Requesters hold `req_valid` and their operands until accepted.
- Requesters may drop `req_valid` before acceptance. The grant is recomputed every IDLE cycle, so a dropped request is never accepted.
- The arbitration pointer advances only on acceptance, to the slot after g. An un-accepted grant does not move it.
- `rsp_out` carries no arithmetic beyond a per-bit AND. There is no width growth or truncation.

## Timing
- Reset values: state = IDLE, `req_ready` = 0, `rsp_valid` = 0, `rsp_out` = 0, `rsp_id` = 0, pointer = 0 (requester 0 highest priority).
- Latency: accept on edge N; `rsp_valid` high from N+2 (after the EVAL edge).
- Best-case throughput: one transaction per 3 cycles, when `rsp_ready` is held high.
- `req_ready` is combinational from state, pointer and `req_valid`. All other outputs are registered.
- Reset mid-transaction, in any state: the in-flight result is discarded, `rsp_valid` drops immediately (asynchronous reset), and the pointer returns to 0.
- Boundary cases:
  - `rsp_ready` high in IDLE or EVAL: ignored.
  - A request arriving in the same cycle HOLD completes: it is not accepted until the next IDLE cycle.
  - Pointer wrap: after a grant to NREQ-1 the pointer returns to 0.

## Configuration
- `GATE_ARB_RR_EN` defined: round-robin arbitration. The search starts at the pointer and wraps modulo NREQ.
- `GATE_ARB_RR_EN` undefined: fixed priority, lowest asserted index wins. The pointer register is not built.
- Ports and timing are identical in both builds.

## Structure
- Package `gate_arb_pkg` holds:
  - state encoding: IDLE = 2'd0, EVAL = 2'd1, HOLD = 2'd2;
  - limits MAX_NREQ = 8 and MAX_WIDTH = 32, checked by an elaboration assertion.
- Sub-module `wide_and` (WIDTH parameter): a generate loop of one `And` per bit. It is the shared datapath that `gate_arbiter` sequences.
- Arbitration logic stays inline in `gate_arbiter`.

## Test plan
- Single request: NREQ=4, WIDTH=8, requester 2 sends A=8'hF0, B=8'h3C. Expect `req_ready`=4'b0100 in the accept cycle, then `rsp_valid` two edges later with `rsp_out`=8'h30, `rsp_id`=2.
- Round-robin contention (`GATE_ARB_RR_EN`): all four requesters held valid, `rsp_ready`=1. Expect grant order 0,1,2,3,0 and one response per 3 cycles.
- Fixed priority (macro undefined): requesters 1 and 3 held valid. Expect requester 1 served every time until it drops; then requester 3.
- Backpressure: `rsp_ready`=0 for 5 cycles in HOLD. Expect `rsp_out`/`rsp_id` stable, `req_ready`=0 throughout, and IDLE on the first `rsp_ready`=1 edge.
- Reset mid-operation: assert `rst` during EVAL. Expect `rsp_valid`=0, `rsp_out`=0 and state IDLE; afterwards requester 0 wins over requester 3 under simultaneous requests.
- Exhaustive 1-bit check (WIDTH=1): all four (a,b) pairs. Expect `rsp_out` = 0,0,0,1.
